// File: rtl/ir_pulse_capture_if.sv
// Event handshake bundle between the IR pulse capture block and its consumer.
// The master drives one mark/space event at a time.
// The slave accepts it with event_ready_in.
interface ir_pulse_capture_if #(
    parameter int DUR_WIDTH = 16
);
    logic                 event_valid_out;
    logic                 event_ready_in;
    logic                 event_mark_out;
    logic [DUR_WIDTH-1:0] event_duration_out;

    modport master (
        output event_valid_out,
        output event_mark_out,
        output event_duration_out,
        input  event_ready_in
    );

    modport slave (
        input  event_valid_out,
        input  event_mark_out,
        input  event_duration_out,
        output event_ready_in
    );
endinterface

// File: rtl/ir_pulse_capture.sv
// IR pulse capture.
// Synchronises a raw carrier-modulated IR input and measures the carrier
// half-period in the transmitter's compare-value encoding (cycles-1).
// Segments the input into mark/space events and offers them through a
// one-entry output buffer with a valid/ready handshake.
module ir_pulse_capture #(
    parameter int WIDTH      = 8,
    parameter int DUR_WIDTH  = 16,
    parameter int GAP_CYCLES = 255
) (
    input  logic             clock_in,
    input  logic             reset_n_in,
    input  logic             enable_in,
    input  logic             ir_in,
    input  logic             clear_overflow_in,
    output logic [WIDTH-1:0] carrier_ocr_out,
    output logic             carrier_valid_out,
    output logic             overflow_out,
    ir_pulse_capture_if.master evt
);

    localparam logic [DUR_WIDTH-1:0] DUR_MAX = '1;
    localparam logic [DUR_WIDTH-1:0] GAP     = DUR_WIDTH'(GAP_CYCLES);
    localparam logic [DUR_WIDTH-1:0] OCR_MAX = {{(DUR_WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE
    } state_t;

    state_t               state_reg;
    logic                 sync1_reg;
    logic                 sync2_reg;
    logic                 dly_reg;
    logic [DUR_WIDTH-1:0] since_edge_reg;
    logic [DUR_WIDTH-1:0] mark_len_reg;

    logic                 ir_edge;
    logic [DUR_WIDTH-1:0] interval;
    logic [DUR_WIDTH:0]   mark_sum;
    logic [DUR_WIDTH-1:0] mark_len_next;
    logic [WIDTH-1:0]     carrier_next;
    logic                 emit;
    logic                 emit_mark;
    logic [DUR_WIDTH-1:0] emit_dur;
    logic                 accept;
    logic                 load;
    logic                 drop;

    // Input synchroniser plus delay flop; runs independently of enable_in
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            dly_reg   <= 1'b0;
        end else begin
            sync1_reg <= ir_in;
            sync2_reg <= sync1_reg;
            dly_reg   <= sync2_reg;
        end
    end

    assign ir_edge = sync2_reg ^ dly_reg;

    // Interval since the previous edge, saturating mark accumulation and carrier encoding
    always_comb begin
        interval      = (since_edge_reg == DUR_MAX) ? DUR_MAX : since_edge_reg + DUR_WIDTH'(1);
        mark_sum      = {1'b0, mark_len_reg} + {1'b0, interval};
        mark_len_next = mark_sum[DUR_WIDTH] ? DUR_MAX : mark_sum[DUR_WIDTH-1:0];
        carrier_next  = (since_edge_reg > OCR_MAX) ? OCR_MAX[WIDTH-1:0] : since_edge_reg[WIDTH-1:0];
    end

    // Decide whether this cycle produces an event, and which one
    always_comb begin
        emit      = 1'b0;
        emit_mark = 1'b0;
        emit_dur  = '0;
        if (enable_in) begin
            case (state_reg)
                ST_MARK: begin
                    if (!ir_edge && since_edge_reg == GAP) begin
                        emit      = 1'b1;
                        emit_mark = 1'b1;
                        emit_dur  = mark_len_reg;
                    end
                end
                ST_SPACE: begin
                    if (ir_edge) begin
                        emit     = 1'b1;
                        emit_dur = interval;
                    end else if (since_edge_reg == DUR_MAX) begin
                        emit     = 1'b1;
                        emit_dur = DUR_MAX;
                    end
                end
                default: ;
            endcase
        end
    end

    assign accept = evt.event_valid_out & evt.event_ready_in;
    assign load   = emit & (~evt.event_valid_out | evt.event_ready_in);
    assign drop   = emit & ~load;

    // Segmentation FSM with edge timer, mark accumulator and carrier measurement
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg         <= ST_IDLE;
            since_edge_reg    <= '0;
            mark_len_reg      <= '0;
            carrier_ocr_out   <= '0;
            carrier_valid_out <= 1'b0;
        end else if (!enable_in) begin
            // carrier_ocr_out deliberately keeps the last measurement
            state_reg         <= ST_IDLE;
            since_edge_reg    <= '0;
            mark_len_reg      <= '0;
            carrier_valid_out <= 1'b0;
        end else begin
            if (ir_edge) begin
                since_edge_reg <= '0;
            end else if (since_edge_reg != DUR_MAX) begin
                since_edge_reg <= since_edge_reg + DUR_WIDTH'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (ir_edge) begin
                        state_reg    <= ST_MARK;
                        mark_len_reg <= '0;
                    end
                end
                ST_MARK: begin
                    if (ir_edge) begin
                        mark_len_reg      <= mark_len_next;
                        carrier_ocr_out   <= carrier_next;
                        carrier_valid_out <= 1'b1;
                    end else if (since_edge_reg == GAP) begin
                        state_reg <= ST_SPACE;
                    end
                end
                ST_SPACE: begin
                    if (ir_edge) begin
                        state_reg    <= ST_MARK;
                        mark_len_reg <= '0;
                    end else if (since_edge_reg == DUR_MAX) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // One-entry event buffer with sticky overflow; a drop beats a clear
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            evt.event_valid_out    <= 1'b0;
            evt.event_mark_out     <= 1'b0;
            evt.event_duration_out <= '0;
            overflow_out           <= 1'b0;
        end else begin
            if (load) begin
                evt.event_valid_out    <= 1'b1;
                evt.event_mark_out     <= emit_mark;
                evt.event_duration_out <= emit_dur;
            end else if (accept) begin
                evt.event_valid_out <= 1'b0;
            end
            if (drop) begin
                overflow_out <= 1'b1;
            end else if (clear_overflow_in) begin
                overflow_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_pulse_capture.sv
// Scoreboard bench for ir_pulse_capture.
// Stimulus pushes the hand-computed expected events into a queue per DUT.
// Monitors pop and compare whenever an event is transferred.
module tb_ir_pulse_capture;

    typedef struct {
        bit mark;
        int dur;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en1 = 1'b0, ir1 = 1'b0, clr1 = 1'b0;
    logic en2 = 1'b0, ir2 = 1'b0, clr2 = 1'b0;
    logic [7:0] ocr1, ocr2;
    logic cv1, cv2, ovf1, ovf2;

    int n_cmp = 0;
    int n_fail = 0;
    exp_t q1[$];
    exp_t q2[$];

    ir_pulse_capture_if #(.DUR_WIDTH(16)) bus1 ();
    ir_pulse_capture_if #(.DUR_WIDTH(10)) bus2 ();

    ir_pulse_capture #(.WIDTH(8), .DUR_WIDTH(16), .GAP_CYCLES(255)) dut1 (
        .clock_in(clk), .reset_n_in(rst_n), .enable_in(en1), .ir_in(ir1),
        .clear_overflow_in(clr1), .carrier_ocr_out(ocr1), .carrier_valid_out(cv1),
        .overflow_out(ovf1), .evt(bus1)
    );

    ir_pulse_capture #(.WIDTH(8), .DUR_WIDTH(10), .GAP_CYCLES(255)) dut2 (
        .clock_in(clk), .reset_n_in(rst_n), .enable_in(en2), .ir_in(ir2),
        .clear_overflow_in(clr2), .carrier_ocr_out(ocr2), .carrier_valid_out(cv2),
        .overflow_out(ovf2), .evt(bus2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic burst1(input int edges, input int period);
        for (int i = 0; i < edges; i++) begin
            ir1 = ~ir1;
            if (i < edges - 1) tick(period);
        end
    endtask

    task automatic burst2(input int edges, input int period);
        for (int i = 0; i < edges; i++) begin
            ir2 = ~ir2;
            if (i < edges - 1) tick(period);
        end
    endtask

    task automatic push1(input bit m, input int d);
        exp_t e;
        e.mark = m;
        e.dur = d;
        q1.push_back(e);
    endtask

    task automatic push2(input bit m, input int d);
        exp_t e;
        e.mark = m;
        e.dur = d;
        q2.push_back(e);
    endtask

    // Monitor for dut1: transfer check plus payload stability under backpressure
    bit hold1 = 1'b0;
    bit hold1_mark;
    int hold1_dur;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold1 = 1'b0;
        end else begin
            if (hold1 && bus1.event_valid_out) begin
                chk("evt1_hold_mark", bus1.event_mark_out, hold1_mark);
                chk("evt1_hold_dur", bus1.event_duration_out, hold1_dur);
            end
            hold1 = bus1.event_valid_out && !bus1.event_ready_in;
            hold1_mark = bus1.event_mark_out;
            hold1_dur = int'(bus1.event_duration_out);
            if (bus1.event_valid_out && bus1.event_ready_in) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL evt1_unexpected: got mark=%0d dur=%0d expected no event",
                             bus1.event_mark_out, bus1.event_duration_out);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("evt1_mark", bus1.event_mark_out, e.mark);
                    chk("evt1_dur", bus1.event_duration_out, e.dur);
                    $display("dut1 event mark=%0d dur=%0d", bus1.event_mark_out, bus1.event_duration_out);
                end
            end
        end
    end

    // Monitor for dut2
    always @(negedge clk) begin
        if (rst_n && bus2.event_valid_out && bus2.event_ready_in) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL evt2_unexpected: got mark=%0d dur=%0d expected no event",
                         bus2.event_mark_out, bus2.event_duration_out);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("evt2_mark", bus2.event_mark_out, e.mark);
                chk("evt2_dur", bus2.event_duration_out, e.dur);
                $display("dut2 event mark=%0d dur=%0d", bus2.event_mark_out, bus2.event_duration_out);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus1.event_ready_in = 1'b0;
        bus2.event_ready_in = 1'b0;
        tick(3);
        chk("rst_valid", bus1.event_valid_out, 0);
        chk("rst_cv", cv1, 0);
        chk("rst_ocr", ocr1, 0);
        chk("rst_ovf", ovf1, 0);
        rst_n = 1'b1;
        tick(2);
        chk("rel_valid", bus1.event_valid_out, 0);

        // Steady carrier: toggle every 4 clocks, 20 edges
        en1 = 1'b1;
        bus1.event_ready_in = 1'b1;
        push1(1'b1, 76);
        ir1 = ~ir1;
        tick(4);
        chk("t1_cv_first_edge", cv1, 0);
        ir1 = ~ir1;
        tick(4);
        chk("t1_ocr", ocr1, 3);
        chk("t1_cv", cv1, 1);
        burst1(18, 4);
        tick(258);
        chk("t1_valid_early", bus1.event_valid_out, 0);
        tick(1);
        chk("t1_valid_rise", bus1.event_valid_out, 1);
        tick(5);
        chk("t1_drained", bus1.event_valid_out, 0);
        en1 = 1'b0;
        tick(2);
        en1 = 1'b1;

        // Two bursts 1000 clocks apart
        push1(1'b1, 20);
        push1(1'b0, 1000);
        push1(1'b1, 24);
        burst1(6, 4);
        tick(1000);
        burst1(5, 6);
        tick(300);
        chk("t2_ocr", ocr1, 5);
        chk("t2_drained", bus1.event_valid_out, 0);
        en1 = 1'b0;
        tick(2);
        en1 = 1'b1;

        // Backpressure across two bursts
        bus1.event_ready_in = 1'b0;
        burst1(4, 4);
        tick(300);
        chk("t3_valid", bus1.event_valid_out, 1);
        chk("t3_dur", bus1.event_duration_out, 12);
        chk("t3_ovf_before", ovf1, 0);
        burst1(4, 5);
        tick(300);
        chk("t3_valid_held", bus1.event_valid_out, 1);
        chk("t3_dur_held", bus1.event_duration_out, 12);
        chk("t3_ovf_set", ovf1, 1);
        push1(1'b1, 12);
        bus1.event_ready_in = 1'b1;
        tick(1);
        chk("t3_drained", bus1.event_valid_out, 0);
        chk("t3_ovf_sticky", ovf1, 1);
        clr1 = 1'b1;
        tick(1);
        clr1 = 1'b0;
        chk("t3_ovf_cleared", ovf1, 0);
        en1 = 1'b0;
        tick(2);
        en1 = 1'b1;

        // Single edge then silence
        push1(1'b1, 0);
        burst1(1, 1);
        tick(300);
        chk("t4_cv", cv1, 0);
        chk("t4_ocr_held", ocr1, 4);
        chk("t4_drained", bus1.event_valid_out, 0);
        en1 = 1'b0;
        tick(2);
        en1 = 1'b1;

        // Enable dropped mid-burst with a pending event
        bus1.event_ready_in = 1'b0;
        burst1(3, 4);
        tick(300);
        chk("t5_pending", bus1.event_valid_out, 1);
        en1 = 1'b0;
        tick(2);
        en1 = 1'b1;
        burst1(3, 4);
        tick(3);
        chk("t5_cv_mid", cv1, 1);
        en1 = 1'b0;
        tick(1);
        chk("t5_cv_cleared", cv1, 0);
        burst1(2, 4);
        tick(300);
        chk("t5_still_valid", bus1.event_valid_out, 1);
        chk("t5_dur", bus1.event_duration_out, 8);
        chk("t5_ovf", ovf1, 0);
        push1(1'b1, 8);
        bus1.event_ready_in = 1'b1;
        tick(2);
        chk("t5_drained", bus1.event_valid_out, 0);
        en1 = 1'b1;
        tick(2);

        // Asynchronous reset mid-burst
        bus1.event_ready_in = 1'b0;
        burst1(3, 4);
        tick(300);
        burst1(3, 4);
        tick(3);
        chk("t6_cv_pre", cv1, 1);
        chk("t6_ovf_pre", ovf1, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", bus1.event_valid_out, 0);
        chk("t6_mark", bus1.event_mark_out, 0);
        chk("t6_dur", bus1.event_duration_out, 0);
        chk("t6_ocr", ocr1, 0);
        chk("t6_cv", cv1, 0);
        chk("t6_ovf", ovf1, 0);
        en1 = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Space saturation on the narrow-duration instance
        en2 = 1'b1;
        bus2.event_ready_in = 1'b1;
        push2(1'b1, 12);
        push2(1'b0, 1023);
        push2(1'b1, 0);
        burst2(4, 4);
        tick(2000);
        chk("t7_ocr", ocr2, 3);
        chk("t7_drained", bus2.event_valid_out, 0);
        burst2(1, 1);
        tick(300);
        chk("t7_ovf", ovf2, 0);

        chk("q1_empty", q1.size(), 0);
        chk("q2_empty", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
